// File: rtl/aes_pkg.sv
// aes_pkg: shared loader FSM states, AES state/column types and byte-slot mapping.
package aes_pkg;
  localparam int NUM_BYTES = 16;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} ld_state_e;
  typedef logic [127:0] aes_state_t;
  typedef logic [31:0] aes_col_t;
  // slot = col*4 + row; transposed streams are row-major
  function automatic logic [3:0] slot_of(input logic [3:0] k, input logic transpose);
    return transpose ? {k[1:0], k[3:2]} : k;
  endfunction
endpackage

// File: rtl/state_loader_columnmaker.sv
// Columnmaker: packs four row bytes into one column, row0 in the top byte.
module Columnmaker #(
  parameter int BYTE_W = 8
) (
  input  logic [BYTE_W-1:0]   DataA,
  input  logic [BYTE_W-1:0]   DataB,
  input  logic [BYTE_W-1:0]   DataC,
  input  logic [BYTE_W-1:0]   DataD,
  output logic [4*BYTE_W-1:0] column
);
  assign column = {DataA, DataB, DataC, DataD};
endmodule

// File: rtl/state_loader.sv
// state_loader: assembles a 16-byte stream into a 128-bit AES state with valid/ready hold.
// STATE_LOADER_TRANSPOSE_EN selects row-major input byte placement.
module state_loader
  import aes_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int BYTE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output aes_state_t        out_state,
  output logic [1:0]        col_idx,
  output logic              busy
);
`ifdef STATE_LOADER_TRANSPOSE_EN
  localparam logic TRANSPOSE = 1'b1;
`else
  localparam logic TRANSPOSE = 1'b0;
`endif
  ld_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] bytes_q [NUM_BYTES];
  logic [BYTE_W-1:0] bytes_d [NUM_BYTES];
  logic acc;
  aes_col_t cols [NUM_COLS];
  assign in_ready  = !rst && state_q != HOLD;
  assign out_valid = state_q == HOLD;
  assign busy      = state_q != IDLE;
  assign col_idx   = TRANSPOSE ? cnt_q[1:0] : cnt_q[3:2];
  always_comb begin
    acc     = in_valid && in_ready && !flush;
    cnt_d   = flush ? 4'd0 : acc ? cnt_q + 4'd1 : cnt_q;
    state_d = flush ? IDLE
            : state_q == HOLD ? (out_ready ? IDLE : HOLD)
            : acc ? (cnt_q == 4'd15 ? HOLD : FILL)
            : state_q;
    bytes_d = bytes_q;
    if (acc) bytes_d[slot_of(cnt_q, TRANSPOSE)] = in_byte;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_BYTES; i++) bytes_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
    end
  end
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    Columnmaker #(.BYTE_W(BYTE_W)) u_col (
      .DataA (bytes_q[4*c]),
      .DataB (bytes_q[4*c+1]),
      .DataC (bytes_q[4*c+2]),
      .DataD (bytes_q[4*c+3]),
      .column(cols[c])
    );
    assign out_state[(NUM_COLS-1-c)*32 +: 32] = cols[c];
  end
endmodule

// File: tb/tb_state_loader.sv
// tb_state_loader: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_state_loader;
`ifdef STATE_LOADER_TRANSPOSE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_ready, out_valid, busy;
  logic [127:0] out_state;
  logic [1:0] col_idx;
  int tests = 0, fails = 0;
  bit m_hold;
  int m_n;
  logic [7:0] st [4][4];
  always #5 clk = ~clk;
  state_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .col_idx(col_idx), .busy(busy)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] exp_state();
    logic [127:0] v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) v[127-32*c-8*r -: 8] = st[c][r];
    return v;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 0; m_n = 0;
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) st[c][r] = 8'h00;
    end else if (flush) begin
      m_hold = 0; m_n = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (TR) st[m_n % 4][m_n / 4] = in_byte;
      else    st[m_n / 4][m_n % 4] = in_byte;
      m_hold = (m_n == 15);
      m_n = (m_n + 1) % 16;
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 128'(in_ready), 128'(!rst && !m_hold));
    chk("out_valid", 128'(out_valid), 128'(m_hold));
    chk("busy", 128'(busy), 128'(m_hold || m_n != 0));
    chk("col_idx", 128'(col_idx), 128'(TR ? m_n % 4 : m_n / 4));
    chk("out_state", out_state, exp_state());
  end
  task automatic cyc(input logic v, input logic [7:0] b, input logic fl, input logic ordy);
    in_valid = v; in_byte = b; flush = fl; out_ready = ordy;
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", out_state, 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 128'(in_ready), 128'h1);
    // back-to-back 00..0F with the consumer always ready
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(k), 1'b0, 1'b1);
    chk("seq_valid", 128'(out_valid), 128'h1);
    chk("seq_state", out_state, TR ? 128'h0004080C0105090D02060A0E03070B0F
                                    : 128'h000102030405060708090A0B0C0D0E0F);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("seq_idle", 128'(busy), 128'h0);
    chk("seq_retain", out_state, TR ? 128'h0004080C0105090D02060A0E03070B0F
                                      : 128'h000102030405060708090A0B0C0D0E0F);
    // sparse load with gaps
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k < 4 ? 8'(8'hAA + 17 * k) : 8'h00, 1'b0, 1'b1);
      if (k == 4) chk("gap_col_idx", 128'(col_idx), 128'h1);
      if (k < 15) cyc(1'b0, 8'hEE, 1'b0, 1'b1);
    end
    chk("gap_state", out_state, TR ? 128'hAA000000BB000000CC000000DD000000
                                     : 128'hAABBCCDD000000000000000000000000);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    // consumer stalls for five cycles
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'hF0 - k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("stall_valid", 128'(out_valid), 128'h1);
    chk("stall_ready", 128'(in_ready), 128'h0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("stall_release", 128'(busy), 128'h0);
    // flush after 7 bytes, colliding with a presented byte
    for (int k = 0; k < 7; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("flush_busy", 128'(busy), 128'h0);
    chk("flush_col", 128'(col_idx), 128'h0);
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    chk("flush_reload", out_state, TR ? 128'h1014181C1115191D12161A1E13171B1F
                                        : 128'h101112131415161718191A1B1C1D1E1F);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    // asynchronous reset mid-load
    for (int k = 0; k < 9; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_state", out_state, 128'h0);
    chk("arst_busy", 128'(busy), 128'h0);
    chk("arst_col", 128'(col_idx), 128'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
    chk("arst_reload", out_state, TR ? 128'h0004080C0105090D02060A0E03070B0F
                                       : 128'h000102030405060708090A0B0C0D0E0F);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
